// File: rtl/pixel_framebuffer.sv
// Double-buffered pixel framebuffer: packed-word unpacker into the back bank,
// scaled 2-cycle scan-out from the front bank, tear-free swaps at frame start.
//
// state  | meaning
// IDLE   | wr_ready high, waiting for a packed word
// UNPACK | writing one pixel of the latched word per cycle to the back bank
module pixel_framebuffer #(
    parameter int              PIX_W      = 8,
    parameter int              FB_W       = 320,
    parameter int              FB_H       = 240,
    parameter int              SCALE_LOG2 = 1,
    parameter logic [PIX_W-1:0] BG_COLOR  = '0,
    parameter int              PA_W       = $clog2(FB_W*FB_H)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [PA_W-1:0]  wr_addr_i,
    input  logic [31:0]      wr_data_i,
    input  logic             swap_req_i,
    output logic             swap_pending_o,
    output logic             front_sel_o,
    input  logic [9:0]       vid_x_i,
    input  logic [9:0]       vid_y_i,
    input  logic             vid_active_i,
    input  logic             vid_frame_start_i,
    output logic [PIX_W-1:0] pix_out_o,
    output logic             pix_valid_o
);

    localparam int PPW    = 32 / PIX_W;
    localparam int CNT_W  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int FB_N   = FB_W * FB_H;
    localparam int IDX_W  = PA_W + 1;
    localparam int PROD_W = PA_W + 11;

    typedef enum logic {
        S_IDLE,
        S_UNPACK
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       data_q, data_d;
    logic [PA_W-1:0]   base_q, base_d;
    logic              bank_q, bank_d;
    logic              swap_pending_q, swap_pending_d;
    logic              front_sel_q, front_sel_d;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [PIX_W-1:0]  wr_pix;
    logic              wr_bank;

    logic [PIX_W-1:0]  mem0_q [FB_N];
    logic [PIX_W-1:0]  mem1_q [FB_N];

    logic [9:0]        sx, sy;
    logic              in_fb;
    logic [PA_W-1:0]   ridx_d;

    logic              active_d1_q, in_fb_d1_q, front_d1_q;
    logic [PA_W-1:0]   ridx_q;
    logic              active_d2_q, in_fb_d2_q;
    logic [PIX_W-1:0]  rd_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            data_q         <= '0;
            base_q         <= '0;
            bank_q         <= 1'b0;
            swap_pending_q <= 1'b0;
            front_sel_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            data_q         <= data_d;
            base_q         <= base_d;
            bank_q         <= bank_d;
            swap_pending_q <= swap_pending_d;
            front_sel_q    <= front_sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        base_d  = base_q;
        bank_d  = bank_q;
        wr_en   = 1'b0;
        wr_idx  = IDX_W'(base_q) + IDX_W'(cnt_q);
        wr_pix  = data_q[cnt_q*PIX_W +: PIX_W];
        wr_bank = bank_q;
        case (state_q)
            S_IDLE: begin
                if (wr_valid_i) begin
                    // Bank is frozen at acceptance so a swap cannot split a word.
                    data_d = wr_data_i;
                    base_d = wr_addr_i;
                    bank_d = ~front_sel_q;
                    cnt_d  = '0;
                    if (PPW == 1) begin
                        wr_en   = 1'b1;
                        wr_idx  = IDX_W'(wr_addr_i);
                        wr_pix  = wr_data_i[PIX_W-1:0];
                        wr_bank = ~front_sel_q;
                    end else begin
                        state_d = S_UNPACK;
                    end
                end
            end
            S_UNPACK: begin
                wr_en = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(PPW - 1))
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Out-of-range pixels are dropped rather than wrapped; the cycle is still spent.
        if (wr_idx >= IDX_W'(FB_N))
            wr_en = 1'b0;
    end

    always_comb begin
        swap_pending_d = swap_pending_q | swap_req_i;
        front_sel_d    = front_sel_q;
        if (vid_frame_start_i && swap_pending_q && (state_q == S_IDLE)) begin
            front_sel_d    = ~front_sel_q;
            swap_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && !wr_bank)
            mem0_q[wr_idx[PA_W-1:0]] <= wr_pix;
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && wr_bank)
            mem1_q[wr_idx[PA_W-1:0]] <= wr_pix;
    end

    always_comb begin
        sx     = vid_x_i >> SCALE_LOG2;
        sy     = vid_y_i >> SCALE_LOG2;
        in_fb  = ({1'b0, sx} < 11'(FB_W)) && ({1'b0, sy} < 11'(FB_H));
        ridx_d = '0;
        if (in_fb)
            ridx_d = PA_W'(PROD_W'(sy) * PROD_W'(FB_W) + PROD_W'(sx));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            active_d1_q <= 1'b0;
            in_fb_d1_q  <= 1'b0;
            front_d1_q  <= 1'b0;
            ridx_q      <= '0;
            active_d2_q <= 1'b0;
            in_fb_d2_q  <= 1'b0;
        end else begin
            active_d1_q <= vid_active_i;
            in_fb_d1_q  <= in_fb;
            front_d1_q  <= front_sel_q;
            ridx_q      <= ridx_d;
            active_d2_q <= active_d1_q;
            in_fb_d2_q  <= in_fb_d1_q;
        end
    end

    always_ff @(posedge clk_i) begin
        rd_q <= front_d1_q ? mem1_q[ridx_q] : mem0_q[ridx_q];
    end

    assign wr_ready_o     = (state_q == S_IDLE);
    assign swap_pending_o = swap_pending_q;
    assign front_sel_o    = front_sel_q;
    assign pix_out_o      = (active_d2_q && in_fb_d2_q) ? rd_q : BG_COLOR;
    assign pix_valid_o    = active_d2_q;

endmodule

// File: doc/pixel_framebuffer.md
Name: pixel_framebuffer

Overview:
Parametrised, double-buffered pixel framebuffer between the processor write path and the VGA scan-out path. It accepts 32-bit packed pixel words over a valid/ready handshake and unpacks them into the back buffer at one pixel per cycle. It streams the front buffer to the VGA timing generator with optional integer upscaling. Buffer swaps occur only at frame start, so scan-out never tears.

Parameters:
PIX_W, 8, bits per pixel; legal values 8, 16, 32 (PPW = 32/PIX_W pixels per word)
FB_W, 320, framebuffer width in pixels
FB_H, 240, framebuffer height in pixels
SCALE_LOG2, 1, upscale factor 2^SCALE_LOG2 applied to both axes (0 = 1x)
BG_COLOR, 0, PIX_W-bit value output outside the active area or outside the framebuffer
PA_W, $clog2(FB_W*FB_H), pixel index width (17 for defaults)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_valid  in  1  write word offered
wr_ready  out  1  unpacker idle; can accept a word
wr_addr  in  PA_W  pixel index of the first pixel in the word (y*FB_W+x)
wr_data  in  32  packed pixels; pixel k = wr_data[k*PIX_W +: PIX_W], LSB first
swap_req  in  1  one-cycle pulse requesting a front/back swap
swap_pending  out  1  swap requested, not yet applied
front_sel  out  1  buffer currently scanned out (0/1); back = ~front_sel
vid_x  in  10  current VGA column
vid_y  in  10  current VGA row
vid_active  in  1  VGA visible region
vid_frame_start  in  1  one-cycle pulse at start of frame (vsync edge)
pix_out  out  PIX_W  pixel for scan-out
pix_valid  out  1  vid_active delayed to align with pix_out

Behaviour:
- Reset values: wr_ready=1, swap_pending=0, front_sel=0, pix_out=BG_COLOR, pix_valid=0. Unpacker state=IDLE. Memory contents are not cleared.
- Storage: two banks of FB_W*FB_H entries, PIX_W bits each. One write port (back bank) and one read port (front bank), both synchronous.
- Unpacker FSM, IDLE/UNPACK:
  - IDLE: wr_ready=1. On wr_valid&&wr_ready, latch wr_data and wr_addr, set cnt=0, and go to UNPACK. If PPW=1, write directly and stay in IDLE.
  - UNPACK: wr_ready=0. Each cycle write pixel cnt to back-bank index base+cnt, then increment cnt. After the write with cnt=PPW-1, return to IDLE; wr_ready=1 on the following cycle.
  - Throughput is one word per PPW+1 cycles.
- Write bounds: pixels with index >= FB_W*FB_H are dropped and do not wrap; the FSM still spends the cycle.
- Back-bank selection is captured when a word is accepted, so a swap never splits a word across banks.
- Swap:
  - swap_req sets swap_pending.
  - On vid_frame_start with swap_pending=1 and FSM=IDLE: toggle front_sel and clear swap_pending in the same cycle.
  - If FSM=UNPACK at frame start, the swap defers to the next vid_frame_start.
  - swap_req coincident with vid_frame_start sets pending only; the swap takes effect at the following frame start.
  - Extra swap_req pulses while pending are idempotent.
- Read pipeline, fixed 2-cycle latency:
  - Stage 1 registers sx=vid_x>>SCALE_LOG2, sy=vid_y>>SCALE_LOG2, in_fb=(sx<FB_W)&&(sy<FB_H), and the registered index sy*FB_W+sx. Use a constant multiply, or a shift-add when FB_W is a power-of-2 sum.
  - Stage 2 reads the front bank.
  - pix_out = (active_d2 && in_fb_d2) ? mem : BG_COLOR; pix_valid = active_d2.
  - front_sel is sampled at stage 1, so a swap is clean from the first active pixel of the new frame.
- Write/read collision: only possible on the same bank, which cannot occur. Writes always target ~front_sel as captured at word acceptance.
- Reset mid-UNPACK: abort immediately; remaining pixels are not written; return to IDLE with wr_ready=1 on the next cycle. Reset also clears the read pipeline to BG/0.

Test Plan:
- Reset, then write word 0xDDCCBBAA at wr_addr=0 (PIX_W=8) -> wr_ready low 4 cycles; back bank 1 holds indices 0..3 = AA,BB,CC,DD; front buffer output unchanged.
- swap_req, then vid_frame_start -> front_sel 0->1, swap_pending 1->0. Scan (x=0,y=0), SCALE_LOG2=1, with active -> pix_out=0xAA two cycles later. x=2,3 -> 0xBB, 0xBB.
- Word at wr_addr=76798 (last two valid) -> indices 76798/76799 written; two overflow pixels dropped, no write to index 0.
- Word accepted, swap_req, then vid_frame_start on the 2nd UNPACK cycle -> no swap. At the next frame_start, front_sel toggles; all 4 pixels are in the old back bank.
- vid_x=700 (sx=350>=FB_W) or vid_active=0 -> pix_out=BG_COLOR after 2 cycles; pix_valid follows vid_active by 2.
- Reset asserted on UNPACK cycle 2 -> only pixels 0..1 written; wr_ready=1 and swap_pending=0 the cycle after reset deasserts.
